cfg_bus_initiator: RTL and testbench

Initiator for the 4-bit address/data/valid/ack configuration bus that the clock handler (baud-rate select) and similar register blocks answer on. It accepts one write command at a time from an upstream source (UART command parser or boot sequencer). It drives the bus and holds valid until ack is seen. It then waits for the responder's read-back (data_out/data_out_valid) and reports completion with a status code. It sits between the command path and every config responder.

---
 rtl/cfg_bus_initiator.sv | 157 +++++++++++++++
 tb/tb_cfg_bus_initiator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_initiator.sv
// Single-command initiator for the 4-bit address/data/valid/ack configuration bus.
// Drives one write, waits for the responder's ack and read-back, and reports a status code.
//
// state    | meaning
// S_IDLE   | cmd_ready high, waiting for an upstream command
// S_REQ    | valid held with frozen address/data until ack or ack timeout
// S_WAIT_RSP | valid low, waiting for data_out_valid or response timeout
// S_DONE   | one-cycle done pulse, status/rsp_data already updated
module cfg_bus_initiator #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ack,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic [1:0]        status
);

  localparam int TMAX = (ACK_TIMEOUT > RSP_TIMEOUT) ? ACK_TIMEOUT : RSP_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_REJECT = 2'b01;
  localparam logic [1:0] ST_NO_ACK = 2'b10;
  localparam logic [1:0] ST_NO_RSP = 2'b11;

  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] RSP_LAST = TW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [TW-1:0]     timer_inc;

  // Saturating count so an oversized timer can never wrap back into range.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    address_d  = address_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    done_d     = 1'b0;
    status_d   = status_q;
    timer_d    = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          address_d = cmd_addr;
          data_d    = cmd_data;
          valid_d   = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        timer_d = timer_inc;
        if (ack) begin
          valid_d = 1'b0;
          timer_d = '0;
          if (data_out_valid) begin
            rsp_data_d = data_out;
            status_d   = (data_out == data_q) ? ST_OK : ST_REJECT;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end else if (timer_q == ACK_LAST) begin
          valid_d  = 1'b0;
          status_d = ST_NO_ACK;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_WAIT_RSP: begin
        timer_d = timer_inc;
        if (data_out_valid) begin
          rsp_data_d = data_out;
          status_d   = (data_out == data_q) ? ST_OK : ST_REJECT;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else if (timer_q == RSP_LAST) begin
          status_d = ST_NO_RSP;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      done_q     <= 1'b0;
      status_q   <= ST_OK;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      address_q  <= address_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done_d;
      status_q   <= status_d;
      timer_q    <= timer_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign address   = address_q;
  assign data      = data_q;
  assign valid     = valid_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_cfg_bus_initiator.sv
// Directed bench for cfg_bus_initiator: stimulus pushes expected {status, rsp_data}
// into a queue that a monitor pops on each done pulse.
module tb_cfg_bus_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       ack;
  logic [3:0] data_out;
  logic       data_out_valid;
  logic [3:0] rsp_data;
  logic       done;
  logic [1:0] status;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  logic [3:0] exp_addr = '0;
  logic [3:0] exp_data = '0;
  int         vlen = 0;
  int         last_vlen = 0;

  cfg_bus_initiator #(
    .ADDR_W(4), .DATA_W(4), .ACK_TIMEOUT(16), .RSP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .address(address), .data(data), .valid(valid), .ack(ack),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .rsp_data(rsp_data), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [1:0] st, input logic [3:0] rsp);
    exp_q.push_back({st, rsp});
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    exp_addr  = a;
    exp_data  = d;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    chk("accept_latency_valid", 32'(valid), 32'd1);
  endtask

  task automatic wait_done(output int n, input int max);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard monitor
  always begin
    @(posedge clk);
    #2;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("sb_status", 32'(status), 32'(e[5:4]));
        chk("sb_rsp_data", 32'(rsp_data), 32'(e[3:0]));
      end
    end
  end

  // Bus monitor: pulse width of valid and address/data stability while it is high
  always begin
    @(posedge clk);
    #2;
    if (valid && !rst) begin
      vlen++;
      if (address !== exp_addr) chk("addr_stable", 32'(address), 32'(exp_addr));
      if (data !== exp_data) chk("data_stable", 32'(data), 32'(exp_data));
    end else if (vlen != 0) begin
      last_vlen = vlen;
      vlen = 0;
    end
  end

  initial begin
    int n;
    int n2;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    ack = 1'b0; data_out = '0; data_out_valid = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Normal write: ack in second valid cycle, read-back one cycle later
    issue(4'b0001, 4'b0010);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_valid_dropped", 32'(valid), 32'd0);
    expect_done(2'b00, 4'b0010);
    data_out = 4'b0010; data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready_low_in_done", 32'(cmd_ready), 32'd0);
    tick();
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_ready_back", 32'(cmd_ready), 32'd1);
    chk("t1_valid_len", 32'(last_vlen), 32'd2);

    // Rejected read-back; a stray cmd_valid during the transaction is ignored
    issue(4'b0001, 4'b1111);
    cmd_valid = 1'b1; cmd_addr = 4'b1110; cmd_data = 4'b0110;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0; cmd_valid = 1'b0;
    expect_done(2'b01, 4'b0010);
    data_out = 4'b0010; data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    tick();
    chk("t2_status_held", 32'(status), 32'd1);
    chk("t2_valid_len", 32'(last_vlen), 32'd2);

    // ack/data_out_valid while idle must not change anything
    ack = 1'b1; data_out = 4'b1010; data_out_valid = 1'b1;
    tick();
    ack = 1'b0; data_out_valid = 1'b0;
    tick();
    chk("idle_ack_valid", 32'(valid), 32'd0);
    chk("idle_ack_ready", 32'(cmd_ready), 32'd1);
    chk("idle_rsp_unchanged", 32'(rsp_data), 32'd2);

    // No ack: valid for exactly 16 cycles, NO_ACK, rsp_data kept
    expect_done(2'b10, 4'b0010);
    issue(4'b1001, 4'b0001);
    wait_done(n, 40);
    chk("t3_cycles_to_done", 32'(n), 32'd16);
    tick();
    chk("t3_valid_len", 32'(last_vlen), 32'd16);

    // No read-back: done 16 cycles after the ack sample, extra ack ignored
    issue(4'b0011, 4'b0101);
    ack = 1'b1;
    tick();
    expect_done(2'b11, 4'b0010);
    tick();
    ack = 1'b0;
    wait_done(n2, 40);
    chk("t4_cycles_to_done", 32'(1 + n2), 32'd16);
    tick();
    chk("t4_valid_len", 32'(last_vlen), 32'd1);

    // Same-cycle ack and read-back goes straight to DONE
    issue(4'b0100, 4'b0001);
    expect_done(2'b00, 4'b0001);
    ack = 1'b1; data_out = 4'b0001; data_out_valid = 1'b1;
    tick();
    ack = 1'b0; data_out_valid = 1'b0;
    chk("t5_done_next_cycle", 32'(done), 32'd1);
    tick();
    chk("t5_valid_len", 32'(last_vlen), 32'd1);

    // Reset two cycles into valid discards the command
    issue(4'b0110, 4'b0011);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_valid_drop_on_rst", 32'(valid), 32'd0);
    tick();
    rst = 1'b0;
    chk("t6_status_reset", 32'(status), 32'd0);
    chk("t6_done_low", 32'(done), 32'd0);
    tick();
    chk("t6_done_still_low", 32'(done), 32'd0);
    issue(4'b0001, 4'b1111);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    expect_done(2'b00, 4'b1111);
    data_out = 4'b1111; data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
    chk("t6_after_rst_done", 32'(done), 32'd1);
    repeat (3) tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
